// File: rtl/tdm_demux_8ch.sv
// rtl/tdm_demux_8ch.sv - TDM receive demultiplexer: slot words into a shadow buffer, committed to ch_data per complete frame
module tdm_demux_8ch #(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 1,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic                     in_sync,
  input  logic [DATA_W-1:0]        in_data,
  output logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic                     frame_valid,
  output logic                     locked,
  output logic [SEL_W-1:0]         slot,
  output logic                     sync_err
);

  typedef enum logic {HUNT, LOCKED} state_t;

  localparam int SH_W = (NUM_CH - 1) * DATA_W;
  localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(NUM_CH - 1);
  localparam logic [SEL_W-1:0] SLOT_ONE  = SEL_W'(1);

  state_t                     state_q, state_d;
  logic [SEL_W-1:0]           slot_q, slot_d;
  // The last slot never lands in the shadow; it goes straight into the commit.
  logic [SH_W-1:0]            shadow_q, shadow_d;
  logic [NUM_CH*DATA_W-1:0]   ch_data_q, ch_data_d;
  logic                       frame_valid_q, frame_valid_d;
  logic                       sync_err_q, sync_err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= HUNT;
      slot_q        <= '0;
      shadow_q      <= '0;
      ch_data_q     <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      shadow_q      <= shadow_d;
      ch_data_q     <= ch_data_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    shadow_d      = shadow_q;
    ch_data_d     = ch_data_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;
    if (in_valid) begin
      unique case (state_q)
        HUNT: begin
          if (in_sync) begin
            shadow_d[DATA_W-1:0] = in_data;
            slot_d               = SLOT_ONE;
            state_d              = LOCKED;
          end
        end
        LOCKED: begin
          if (in_sync) begin
            // An early sync restarts the frame on this word; the partial frame is dropped.
            sync_err_d           = (slot_q != '0);
            shadow_d[DATA_W-1:0] = in_data;
            slot_d               = SLOT_ONE;
          end else if (slot_q == '0) begin
            sync_err_d = 1'b1;
            state_d    = HUNT;
          end else if (slot_q == LAST_SLOT) begin
            ch_data_d     = {in_data, shadow_q};
            frame_valid_d = 1'b1;
            slot_d        = '0;
          end else begin
            shadow_d[int'(slot_q)*DATA_W +: DATA_W] = in_data;
            slot_d = slot_q + 1'b1;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  assign ch_data     = ch_data_q;
  assign frame_valid = frame_valid_q;
  assign sync_err    = sync_err_q;
  assign locked      = (state_q == LOCKED);
  assign slot        = slot_q;

endmodule

// File: tb/tb_tdm_demux_8ch.sv
// tb/tb_tdm_demux_8ch.sv - self-checking bench for tdm_demux_8ch against a frame-level reference model
module tb_tdm_demux_8ch;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_sync = 1'b0;
  logic [0:0] in_data = 1'b0;
  logic [7:0] ch_data;
  logic       frame_valid;
  logic       locked;
  logic [2:0] slot;
  logic       sync_err;

  int n_pass = 0;
  int n_total = 0;

  // reference model: frame position and collected words
  bit       m_locked;
  int       m_pos;
  bit       m_words[8];
  bit [7:0] m_frame;
  bit       m_fv;
  bit       m_err;

  tdm_demux_8ch dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sync(in_sync),
    .in_data(in_data), .ch_data(ch_data), .frame_valid(frame_valid),
    .locked(locked), .slot(slot), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    else n_pass++;
  endtask

  task automatic model_reset();
    m_locked = 0; m_pos = 0; m_frame = '0; m_fv = 0; m_err = 0;
    for (int i = 0; i < 8; i++) m_words[i] = 0;
  endtask

  task automatic model_step(input bit v, input bit s, input bit d);
    m_fv = 0; m_err = 0;
    if (!v) return;
    if (!m_locked) begin
      if (s) begin m_words[0] = d; m_pos = 1; m_locked = 1; end
    end else if (s) begin
      m_err = (m_pos != 0);
      m_words[0] = d; m_pos = 1;
    end else if (m_pos == 0) begin
      m_err = 1; m_locked = 0;
    end else begin
      m_words[m_pos] = d;
      if (m_pos == 7) begin
        for (int k = 0; k < 8; k++) m_frame[k] = m_words[k];
        m_fv = 1; m_pos = 0;
      end else m_pos++;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".ch_data"}, ch_data, m_frame);
    check({tag, ".frame_valid"}, frame_valid, m_fv);
    check({tag, ".sync_err"}, sync_err, m_err);
    check({tag, ".locked"}, locked, m_locked);
    check({tag, ".slot"}, slot, m_pos);
    check({tag, ".excl"}, frame_valid & sync_err, 0);
  endtask

  task automatic cycle(input bit v, input bit s, input bit d, input string tag);
    in_valid = v; in_sync = s; in_data = d;
    @(posedge clk); #1;
    model_step(v, s, d);
    check_outputs(tag);
  endtask

  task automatic send_frame(input bit [7:0] pat, input string tag);
    for (int k = 0; k < 8; k++) cycle(1, k == 0, pat[k], tag);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, $urandom_range(0, 1), $urandom_range(0, 1), "idle");
  endtask

  initial begin
    int fv_count;
    bit [7:0] prev;
    model_reset();

    // reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      in_valid = $urandom_range(0, 1); in_sync = $urandom_range(0, 1); in_data = $urandom_range(0, 1);
      @(posedge clk); #1;
      check("rst.ch_data", ch_data, 0);
      check("rst.locked", locked, 0);
      check("rst.slot", slot, 0);
      check("rst.pulses", {frame_valid, sync_err}, 0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle(1, 0, $urandom_range(0, 1), "hunt_nosync");
    idle(2);

    // clean frames
    send_frame(8'b0100_1101, "frame1");
    check("frame1.value", ch_data, 8'h4D);
    check("frame1.fv", frame_valid, 1);
    send_frame(8'b0111_1110, "frame2");
    check("frame2.value", ch_data, 8'h7E);
    cycle(0, 0, 0, "after2");
    check("frame2.fv_drop", frame_valid, 0);

    // gaps after slots 2 and 5
    fv_count = 0;
    for (int k = 0; k < 8; k++) begin
      cycle(1, k == 0, k == 0 || k == 2 || k == 3 || k == 6, "gap");
      fv_count += frame_valid;
      if (k == 2 || k == 5) begin
        for (int g = 0; g < 3; g++) begin
          cycle(0, 0, 0, "gap_idle");
          check("gap.slot_hold", slot, k + 1);
          fv_count += frame_valid;
        end
      end
    end
    cycle(0, 0, 0, "gap_end");
    fv_count += frame_valid;
    check("gap.value", ch_data, 8'h4D);
    check("gap.fv_count", fv_count, 1);

    // early sync: 4 words then a sync word, then 7 more
    for (int k = 0; k < 4; k++) cycle(1, k == 0, 0, "early_pre");
    cycle(1, 1, 1, "early_sync");
    check("early.err", sync_err, 1);
    check("early.held", ch_data, 8'h4D);
    check("early.slot", slot, 1);
    for (int k = 1; k < 8; k++) cycle(1, 0, k[0], "early_post");
    check("early.commit", ch_data, 8'b1010_1011);

    // missing sync
    send_frame(8'h96, "miss_frame");
    cycle(1, 0, 1, "miss");
    check("miss.err", sync_err, 1);
    check("miss.locked", locked, 0);
    check("miss.held", ch_data, 8'h96);
    for (int i = 0; i < 5; i++) cycle(1, 0, $urandom_range(0, 1), "miss_ignore");
    check("miss.still_hunt", {locked, slot}, 0);

    // exhaustive pattern sweep with per-channel mapping
    for (int p = 0; p < 256; p++) begin
      send_frame(p[7:0], "sweep");
      for (int k = 0; k < 8; k++) check($sformatf("sweep.ch%0d", k), ch_data[k], p[k]);
    end

    // asynchronous reset mid-frame at slot 5
    for (int k = 0; k < 5; k++) cycle(1, k == 0, 1, "mid_pre");
    check("mid.slot5", slot, 5);
    #2 rst_n = 1'b0;
    #1;
    check("mid.ch_clear", ch_data, 0);
    check("mid.slot_clear", slot, 0);
    check("mid.locked_clear", locked, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    send_frame(8'hC3, "post_rst");
    check("post_rst.value", ch_data, 8'hC3);

    // randomized stream with occasional sync faults
    for (int i = 0; i < 1500; i++) begin
      bit v, s;
      v = ($urandom_range(0, 9) < 7);
      s = (m_locked ? (m_pos == 0) : ($urandom_range(0, 3) == 0)) ^ ($urandom_range(0, 19) == 0);
      prev = m_frame;
      cycle(v, s, $urandom_range(0, 1), "rand");
      if (!m_fv) check("rand.hold", ch_data, prev);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/tdm_demux_8ch.md
Name: tdm_demux_8ch

Overview:
- Time-division demultiplexer: the receive end of the 8:1 channel-select path.
- Takes one slot word per valid cycle from a serial TDM stream, with a frame-sync marker on slot 0.
- Distributes the slots to NUM_CH parallel channel outputs through a shadow buffer, so the outputs always hold one complete, coherent frame.
- Sits after the link serialiser; feeds per-channel consumers.

Parameters:
- NUM_CH, 8, number of channels (slots per frame); must be ≥2.
- DATA_W, 1, bits per slot word.
- SEL_W, $clog2(NUM_CH), slot index width; derived, do not override.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data/in_sync valid this cycle.
- in_sync  input  1  high with the slot-0 word of each frame.
- in_data  input  DATA_W  slot word.
- ch_data  output  NUM_CH*DATA_W  last complete frame; channel k at bits [k*DATA_W +: DATA_W].
- frame_valid  output  1  one-cycle pulse when ch_data is updated.
- locked  output  1  high while in LOCKED state.
- slot  output  SEL_W  index the next valid word will be written to.
- sync_err  output  1  one-cycle pulse on a sync violation.

Behaviour:
- Reset (async assert, sync release):
  - ch_data=0, shadow=0, frame_valid=0, locked=0, slot=0, sync_err=0, state=HUNT.
- All outputs are registered. in_valid=0 cycles change nothing; pulses drop to 0.
- HUNT state:
  - in_valid&&!in_sync: word discarded, no error.
  - in_valid&&in_sync: shadow[0]<=in_data, slot<=1, go LOCKED.
- LOCKED state, in_valid=1:
  - slot==0 && in_sync, or 0<slot<NUM_CH-1 && !in_sync: shadow[slot]<=in_data, slot<=slot+1.
  - slot==NUM_CH-1 && !in_sync: ch_data<={in_data, shadow[NUM_CH-2:0]}, frame_valid=1 next cycle, slot<=0 (wrap), stay LOCKED.
  - slot!=0 && in_sync (early sync): sync_err=1; partial frame discarded. The word is treated as the new slot 0: shadow[0]<=in_data, slot<=1, stay LOCKED.
  - slot==0 && !in_sync (missing sync): sync_err=1, word discarded, slot<=0, go HUNT.
- Latency: the last slot word is visible on ch_data, with frame_valid, one cycle after its in_valid edge.
- ch_data changes only on frame completion. Aborted or partial frames never reach ch_data; the previous frame is held.
- Shadow entries are not cleared on abort; stale entries are overwritten before any later commit.
- Gaps (in_valid=0) mid-frame are legal; slot position is held.
- frame_valid and sync_err are never high in the same cycle.
- Reset mid-frame: everything returns to reset values immediately; ch_data is cleared, not held.
- locked follows state with the same registered timing: it falls on the cycle sync_err flags a missing sync.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> ch_data=0, locked=0, slot=0, frame_valid=0, sync_err=0. Deassert -> no change until a sync word arrives.
- Clean frames, DATA_W=1, NUM_CH=8:
  - Send sync+words 1,0,1,1,0,0,1,0 (slot 0→7) -> one cycle after slot 7: ch_data=8'b0100_1101, frame_valid single pulse, slot=0, locked=1.
  - Repeat with 0,1,1,1,1,1,1,0 back to back -> ch_data=8'b0111_1110.
- Gaps: same first frame with in_valid=0 for 3 cycles after slots 2 and 5 -> identical ch_data; frame_valid exactly once; slot holds across gaps.
- Early sync: after a committed frame F, send 4 words then in_sync -> sync_err pulse, ch_data still F, slot=1. Then 7 more words -> new frame commits with the resync word in ch0.
- Missing sync: send a full frame, then a slot-0 word with in_sync=0 -> sync_err pulse, locked=0, ch_data unchanged. Non-sync words are then ignored until in_sync.
- Exhaustive sweep: all 2^8 channel patterns framed back to back -> ch_data equals the pattern each frame, with the channel-k mapping checked for every k. Also assert rst_n mid-frame (slot=5) -> immediate clear; the next frame commits correctly.
